// File: rtl/rom_arbiter_pkg.sv
// rom_arbiter_pkg: shared widths, FSM encoding and requester IDs for the ROM burst arbiter
package rom_arbiter_pkg;
  localparam int AW = 12;
  localparam int DW = 8;
  localparam int LW = 4;
  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;
endpackage

// File: rtl/rom_arbiter_if.sv
// rom_arbiter_if: requester handshakes, ROM address/data and tagged read-return bundle
interface rom_arbiter_if;
  import rom_arbiter_pkg::*;
  logic          req0, req1;
  logic [AW-1:0] addr0, addr1;
  logic [LW-1:0] len0, len1;
  logic          ack0, ack1;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic [DW-1:0] rdata;
  logic          rvalid0, rvalid1, rlast, busy;
  modport master (
    output req0, addr0, len0, req1, addr1, len1, rom_data,
    input  ack0, ack1, rom_addr, rdata, rvalid0, rvalid1, rlast, busy
  );
  modport slave (
    input  req0, addr0, len0, req1, addr1, len1, rom_data,
    output ack0, ack1, rom_addr, rdata, rvalid0, rvalid1, rlast, busy
  );
endinterface

// File: rtl/rom_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin pick; ptr breaks the tie when both request
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic ptr,
  output logic grant_valid,
  output logic grant_id
);
  assign grant_valid = req0 | req1;
  assign grant_id    = (req0 & req1) ? ptr : req1;
endmodule

// File: rtl/rom_arbiter.sv
// rom_arbiter: round-robin burst-read controller sharing one asynchronous ROM between two requesters
module rom_arbiter
  import rom_arbiter_pkg::*;
(
  input logic         clk,
  input logic         reset,
  rom_arbiter_if.slave bus
);
  state_t        state, state_n;
  logic [AW-1:0] addr_q, addr_n;
  logic [LW-1:0] cnt, cnt_n;
  logic [DW-1:0] rdata_q, rdata_n;
  logic          id, id_n, ptr, ptr_n;
  logic          ack0_q, ack0_n, ack1_q, ack1_n;
  logic          rv0_q, rv0_n, rv1_q, rv1_n, rlast_q, rlast_n;
  logic          gv, gid;
  rr_arb2 u_arb (
    .req0       (bus.req0),
    .req1       (bus.req1),
    .ptr        (ptr),
    .grant_valid(gv),
    .grant_id   (gid)
  );
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      addr_q  <= '0;
      cnt     <= '0;
      rdata_q <= '0;
      id      <= REQ0;
      ptr     <= REQ0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
      rlast_q <= 1'b0;
    end else begin
      state   <= state_n;
      addr_q  <= addr_n;
      cnt     <= cnt_n;
      rdata_q <= rdata_n;
      id      <= id_n;
      ptr     <= ptr_n;
      ack0_q  <= ack0_n;
      ack1_q  <= ack1_n;
      rv0_q   <= rv0_n;
      rv1_q   <= rv1_n;
      rlast_q <= rlast_n;
    end
  end
  // The final beat is registered on the last BURST edge, so arbitration overlaps it in IDLE
  always_comb begin
    state_n = state;
    addr_n  = addr_q;
    cnt_n   = cnt;
    rdata_n = rdata_q;
    id_n    = id;
    ptr_n   = ptr;
    ack0_n  = 1'b0;
    ack1_n  = 1'b0;
    rv0_n   = 1'b0;
    rv1_n   = 1'b0;
    rlast_n = 1'b0;
    if (state == IDLE) begin
      if (gv) begin
        state_n = BURST;
        ack0_n  = gid == REQ0;
        ack1_n  = gid == REQ1;
        addr_n  = gid ? bus.addr1 : bus.addr0;
        cnt_n   = gid ? bus.len1 : bus.len0;
        id_n    = gid;
        ptr_n   = ~gid;
      end
    end else begin
      rdata_n = bus.rom_data;
      rv0_n   = id == REQ0;
      rv1_n   = id == REQ1;
      rlast_n = cnt == '0;
      state_n = (cnt == '0) ? IDLE : BURST;
      addr_n  = (cnt == '0) ? addr_q : addr_q + 1'b1;
      cnt_n   = (cnt == '0) ? cnt : cnt - 1'b1;
    end
  end
  assign bus.ack0     = ack0_q;
  assign bus.ack1     = ack1_q;
  assign bus.rom_addr = addr_q;
  assign bus.rdata    = rdata_q;
  assign bus.rvalid0  = rv0_q;
  assign bus.rvalid1  = rv1_q;
  assign bus.rlast    = rlast_q;
  assign bus.busy     = state == BURST;
endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: directed-vector bench for rom_arbiter with a ROM model Dout = addr[7:0] ^ 8'hA5
module tb_rom_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int errs = 0;
  int checks = 0;
  rom_arbiter_if bus ();
  rom_arbiter dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  assign bus.rom_data = bus.rom_addr[7:0] ^ 8'hA5;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  always @(negedge clk)
    if (reset) chk("excl", {30'd0, bus.rvalid0 & bus.rvalid1, bus.rlast & ~(bus.rvalid0 | bus.rvalid1)}, 0);
  logic [7:0]  b2[4] = '{8'hB5, 8'hB4, 8'hB7, 8'hB6};
  logic [7:0]  bw[4] = '{8'h5B, 8'h5A, 8'hA5, 8'hA4};
  logic [11:0] aw[4] = '{12'hFFF, 12'h000, 12'h001, 12'h001};
  logic [7:0]  b6[4] = '{8'hE5, 8'hE4, 8'hE7, 8'hE6};
  initial begin
    bus.req0 = 1'b1; bus.addr0 = 12'h010; bus.len0 = 4'd3;
    bus.req1 = 1'b0; bus.addr1 = 12'h000; bus.len1 = 4'd0;
    step(3);
    chk("rst_ack0", bus.ack0, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rv0", bus.rvalid0, 0);
    chk("rst_rlast", bus.rlast, 0);
    chk("rst_addr", bus.rom_addr, 0);
    chk("rst_rdata", bus.rdata, 0);
    reset = 1'b1;
    step;
    chk("g0_ack0", bus.ack0, 1);
    chk("g0_busy", bus.busy, 1);
    chk("g0_addr", bus.rom_addr, 12'h010);
    bus.req0 = 1'b0; bus.addr0 = 12'hABC; bus.len0 = 4'd15;
    for (int i = 0; i < 4; i++) begin
      step;
      chk("b0_ack0", bus.ack0, 0);
      chk("b0_rv0", bus.rvalid0, 1);
      chk("b0_rdata", bus.rdata, b2[i]);
      chk("b0_rlast", bus.rlast, i == 3);
      chk("b0_busy", bus.busy, i != 3);
    end
    step;
    chk("b0_end_rv0", bus.rvalid0, 0);
    chk("b0_end_rlast", bus.rlast, 0);
    chk("b0_end_ack0", bus.ack0, 0);
    reset = 1'b0;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    bus.addr0 = 12'h020; bus.addr1 = 12'h030; bus.len0 = 4'd0; bus.len1 = 4'd0;
    step(2);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step;
      chk("rr_ack0", bus.ack0, i % 2 == 0);
      chk("rr_ack1", bus.ack1, i % 2 == 1);
      step;
      chk("rr_rv0", bus.rvalid0, i % 2 == 0);
      chk("rr_rv1", bus.rvalid1, i % 2 == 1);
      chk("rr_rdata", bus.rdata, (i % 2 == 1) ? 8'h95 : 8'h85);
      chk("rr_rlast", bus.rlast, 1);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    step;
    chk("rr_idle_ack", {bus.ack0, bus.ack1}, 0);
    chk("rr_idle_busy", bus.busy, 0);
    bus.req1 = 1'b1; bus.addr1 = 12'hFFE; bus.len1 = 4'd3;
    step;
    chk("wr_ack1", bus.ack1, 1);
    chk("wr_addr0", bus.rom_addr, 12'hFFE);
    bus.req1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step;
      chk("wr_rv1", bus.rvalid1, 1);
      chk("wr_rdata", bus.rdata, bw[i]);
      chk("wr_addr", bus.rom_addr, aw[i]);
      chk("wr_rlast", bus.rlast, i == 3);
    end
    bus.req0 = 1'b1; bus.addr0 = 12'h040; bus.len0 = 4'd3;
    step;
    chk("pl_ack0", bus.ack0, 1);
    bus.req0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step;
      chk("pl_ack1", bus.ack1, 0);
      chk("pl_rdata", bus.rdata, b6[i]);
      chk("pl_rlast", bus.rlast, i == 3);
      bus.req1 = (i == 0) || (i == 3);
      bus.addr1 = 12'h200; bus.len1 = 4'd0;
    end
    step;
    chk("pl_late_ack1", bus.ack1, 1);
    chk("pl_late_ack0", bus.ack0, 0);
    bus.req1 = 1'b0;
    step;
    chk("pl_late_rv1", bus.rvalid1, 1);
    chk("pl_late_rdata", bus.rdata, 8'hA5);
    chk("pl_late_rlast", bus.rlast, 1);
    bus.req1 = 1'b1; bus.addr1 = 12'h100; bus.len1 = 4'd15;
    step;
    chk("ab_ack1", bus.ack1, 1);
    bus.req1 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step;
      chk("ab_rv1", bus.rvalid1, 1);
      chk("ab_rdata", bus.rdata, 32'(8'(i) ^ 8'hA5));
      chk("ab_rlast", bus.rlast, 0);
    end
    reset = 1'b0;
    step;
    chk("ab_rv1_off", bus.rvalid1, 0);
    chk("ab_rlast_off", bus.rlast, 0);
    chk("ab_busy_off", bus.busy, 0);
    chk("ab_addr_off", bus.rom_addr, 0);
    chk("ab_rdata_off", bus.rdata, 0);
    reset = 1'b1;
    bus.req0 = 1'b1; bus.addr0 = 12'h005; bus.len0 = 4'd0;
    step;
    chk("ab_ack0", bus.ack0, 1);
    bus.req0 = 1'b0;
    step;
    chk("ab_rv0", bus.rvalid0, 1);
    chk("ab_rdata0", bus.rdata, 8'hA0);
    chk("ab_rlast0", bus.rlast, 1);
    bus.req0 = 1'b1; bus.addr0 = 12'h000; bus.len0 = 4'd2;
    step;
    chk("pr_ack0", bus.ack0, 1);
    bus.req0 = 1'b0;
    step;
    reset = 1'b0;
    step;
    reset = 1'b1;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    step;
    chk("pr_ack0_after", bus.ack0, 1);
    chk("pr_ack1_after", bus.ack1, 0);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    step(3);
    chk("fin_busy", bus.busy, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
